// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX/MEM status and go button into the sequencer;
// pipeline enables, flushes, halt flag and performance counters out of it.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             ex_memread;
  logic             ex_regwrite;
  logic [REG_W-1:0] ex_rd;
  logic             ex_redirect;
  logic             ex_halt;
  logic             mem_req;
  logic             mem_ack;
  logic             go;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  id_rs, id_rt, id_rs_used, id_rt_used,
           ex_memread, ex_regwrite, ex_rd, ex_redirect, ex_halt,
           mem_req, mem_ack, go,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           halted, cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    output id_rs, id_rt, id_rs_used, id_rt_used,
           ex_memread, ex_regwrite, ex_rd, ex_redirect, ex_halt,
           mem_req, mem_ack, go,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           halted, cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage MIPS pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int CNT_W      = 32,
  parameter int RESUME_DLY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.master hc
);

  localparam logic [1:0]       ST_RUN    = 2'd0;
  localparam logic [1:0]       ST_HALT   = 2'd1;
  localparam logic [1:0]       ST_RESUME = 2'd2;
  localparam logic [7:0]       RCNT_INIT = 8'(RESUME_DLY - 1);
  localparam logic [REG_W-1:0] REG_ZERO  = '0;

  logic [1:0] state, state_nxt;
  logic [7:0] rcnt, rcnt_nxt;
  logic       go_q;
  logic       gedge;
  logic       luse;
  logic       redirect_take;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted;

  assign gedge = hc.go & ~go_q;

  // $0 is never a real dependency, so a load into it cannot cause a stall.
  assign luse = hc.ex_memread & hc.ex_regwrite & (hc.ex_rd != REG_ZERO)
              & ((hc.id_rs_used & (hc.id_rs == hc.ex_rd))
               | (hc.id_rt_used & (hc.id_rt == hc.ex_rd)));

  always_comb begin
    state_nxt     = state;
    rcnt_nxt      = rcnt;
    redirect_take = 1'b0;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_en       = 1'b1;
    idex_flush    = 1'b0;
    exmem_en      = 1'b1;
    halted        = 1'b0;
    case (state)
      ST_RUN: begin
        if (hc.mem_req & ~hc.mem_ack) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
        end else if (hc.ex_halt) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_nxt  = ST_HALT;
        end else if (hc.ex_redirect) begin
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
          redirect_take = 1'b1;
        end else if (luse) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      ST_HALT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        halted   = 1'b1;
        if (gedge) begin
          rcnt_nxt  = RCNT_INIT;
          state_nxt = ST_RESUME;
        end
      end
      ST_RESUME: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        if (rcnt == 8'd0) begin
          state_nxt = ST_RUN;
        end else begin
          rcnt_nxt = rcnt - 8'd1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      rcnt  <= 8'd0;
      go_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      go_q  <= hc.go;
    end
  end

  assign hc.pc_en      = pc_en;
  assign hc.ifid_en    = ifid_en;
  assign hc.ifid_flush = ifid_flush;
  assign hc.idex_en    = idex_en;
  assign hc.idex_flush = idex_flush;
  assign hc.exmem_en   = exmem_en;
  assign hc.halted     = halted;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, stall_q, flush_q;
  logic             in_run;

  assign in_run = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (in_run)          cycle_q <= cycle_q + 1'b1;
      if (in_run & ~pc_en) stall_q <= stall_q + 1'b1;
      if (redirect_take)   flush_q <= flush_q + 1'b1;
    end
  end

  assign hc.cycle_cnt = cycle_q;
  assign hc.stall_cnt = stall_q;
  assign hc.flush_cnt = flush_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect_take;
  assign hc.cycle_cnt = {CNT_W{1'b0}};
  assign hc.stall_cnt = {CNT_W{1'b0}};
  assign hc.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
